generic_1clk_fifo_env_ram: RTL and testbench
============================================

Name: generic_1clk_fifo_env_ram

Overview:
- Parametrised single-clock FIFO with a built-in 1r1w storage array (bit-maskable write, 1-cycle registered read).
- Successor to the fixed a256d36 dual-clock envelopes. Adds arbitrary width and depth, including non-2^n depth, programmable almost-full/almost-empty flags, sticky clearable errors, and optional first-word-fall-through.
- Used as the same-domain buffer between soc_building_blocks datapath stages.

Parameters:
- DAT_WIDTH, 36: data and mask width.
- NUM_OF_ENTRIES, 256: capacity in words. Any value from 2 to 2^PTR_WIDTH; 2^n is not required.
- PTR_WIDTH, 8: address width, equal to ceil(log2(NUM_OF_ENTRIES)).
- AFULL_TH, 240: afull asserts when entry_used >= AFULL_TH.
- AEMPTY_TH, 16: aempty asserts when entry_used <= AEMPTY_TH.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- wr_op  in  1  write request.
- wr_data  in  DAT_WIDTH  write data.
- wr_mask  in  DAT_WIDTH  per-bit write enable. 1 = write the bit; 0 = the stored bit keeps its old array content.
- full  out  1  no write will be accepted.
- afull  out  1  almost full.
- wr_full_err  out  1  sticky: a write was attempted while full.
- rd_op  in  1  read/pop request.
- rd_data  out  DAT_WIDTH  read data.
- rd_valid  out  1  rd_data qualifier (meaning depends on mode).
- empty  out  1  no read will be accepted.
- aempty  out  1  almost empty.
- rd_empty_err  out  1  sticky: a read was attempted while empty.
- entry_used  out  PTR_WIDTH+1  words accepted and not yet popped.
- err_clr  in  1  synchronous clear of both sticky errors.

Behaviour:
- Reset (async, reset_n=0) values:
  - wr_ptr = rd_ptr = 0, entry_used = 0.
  - empty = 1, aempty = 1 (AEMPTY_TH >= 0), full = 0, afull = 0.
  - rd_valid = 0, rd_data = 0, both errors = 0.
  - Array contents are not reset.
- Reset mid-operation discards all contents and in-flight reads immediately. rd_valid drops in the same cycle as reset asserts.
- All flags and errors are registered. Flags are decoded from the registered entry_used.
- Write accept = wr_op & !full. The word goes to mem[wr_ptr] at the clock edge.
- Write rejected = wr_op & full. The array and pointers are unchanged; wr_full_err sets next cycle.
- Pointer wrap: each pointer increments and wraps from NUM_OF_ENTRIES-1 to 0. No power-of-2 arithmetic.
- entry_used arithmetic:
  - +1 on write accept only, -1 on read accept only.
  - Unchanged when both are accepted in the same cycle, including at entry_used = 1 and entry_used = NUM_OF_ENTRIES-1.
- full = (entry_used == NUM_OF_ENTRIES). Write and read acceptance use the registered flags of the current cycle:
  - Full with wr_op & rd_op: the read is accepted, the write is rejected and sets the error.
  - Empty with wr_op & rd_op: the write is accepted, the read is rejected and sets the error.
- err_clr clears both errors. If err_clr and a new error occur in the same cycle, the set wins.
- Default mode (macro off):
  - empty = (entry_used == 0).
  - Read accept = rd_op & !empty, reading mem[rd_ptr].
  - rd_data is updated and rd_valid=1 one cycle after the accept (1-cycle pulse per accepted read).
  - rd_data holds its last value otherwise.
- Write to an empty FIFO in cycle N: empty = 0 at N+1; rd_op at N+1 returns the data with rd_valid at N+2.
- Same-cycle read and write to the same address cannot occur in default mode: reading requires entry_used >= 1, so rd_ptr != wr_ptr, except when full, where the write is rejected.

Optional Feature:
- Macro GENERIC_1CLK_FIFO_FWFT_EN.
- When defined (first-word-fall-through):
  - The head word is prefetched from the array into an output register. rd_valid=1 means rd_data is the current head.
  - empty = !rd_valid. rd_op pops the head; rd_op while rd_valid=0 is a rejected read and sets rd_empty_err.
  - The prefetch refills back-to-back, so a sustained rd_op on a non-empty FIFO gives one word per cycle.
  - A write to an empty FIFO in cycle N gives rd_valid=1 with that data at N+2.
  - entry_used still counts every unpopped word, including the one in the output register. During fill latency, entry_used=1 with empty=1 is legal.
  - Capacity remains NUM_OF_ENTRIES.
- When not defined: default-mode behaviour above. No prefetch register or extra control is built.

Test Plan:
- Reset then 256 writes (data = index), NUM_OF_ENTRIES=256, no reads:
  - afull first at entry_used=240, full at 256.
  - 257th write sets wr_full_err, and entry_used stays 256.
- Drain all 256:
  - rd_data sequence 0..255 in order.
  - aempty at entry_used<=16; empty after the last pop.
  - One extra rd_op sets rd_empty_err; err_clr clears it next cycle.
- NUM_OF_ENTRIES=5, 3 rounds of write 5 / read 5 with data 0x1..0xF:
  - Pointers wrap 4->0 and order is preserved across wraps.
- Mask: write 0xF_FFFF_FFFF, then fill the depth so the same address is rewritten with data 0 and mask 0x0_0000_FFFF:
  - The read of that address returns 0xF_FFFF_0000.
- Simultaneous rd_op and wr_op:
  - At entry_used=3: entry_used stays 3.
  - At full: read accepted, write flagged.
  - At empty: write accepted, read flagged.
- FWFT build:
  - Write 0xA at cycle N: rd_valid=1 and rd_data=0xA at N+2.
  - A continuous rd_op stream over 10 words pops 1 word per cycle.
  - Assert reset_n=0 mid-stream: rd_valid=0 and entry_used=0 immediately.

Source files
------------

// File: rtl/generic_1clk_fifo_env_ram.sv
// rtl/generic_1clk_fifo_env_ram.sv - single-clock FIFO with bit-maskable 1r1w array
// Optional first-word-fall-through output stage: GENERIC_1CLK_FIFO_FWFT_EN.
module generic_1clk_fifo_env_ram #(
    parameter int DAT_WIDTH      = 36,
    parameter int NUM_OF_ENTRIES = 256,
    parameter int PTR_WIDTH      = 8,
    parameter int AFULL_TH       = 240,
    parameter int AEMPTY_TH      = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wr_op,
    input  logic [DAT_WIDTH-1:0] wr_data,
    input  logic [DAT_WIDTH-1:0] wr_mask,
    output logic                 full,
    output logic                 afull,
    output logic                 wr_full_err,
    input  logic                 rd_op,
    output logic [DAT_WIDTH-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 empty,
    output logic                 aempty,
    output logic                 rd_empty_err,
    output logic [PTR_WIDTH:0]   entry_used,
    input  logic                 err_clr
);

    localparam logic [PTR_WIDTH:0]   CAP      = (PTR_WIDTH+1)'(NUM_OF_ENTRIES);
    localparam logic [PTR_WIDTH:0]   AF_LVL   = (PTR_WIDTH+1)'(AFULL_TH);
    localparam logic [PTR_WIDTH:0]   AE_LVL   = (PTR_WIDTH+1)'(AEMPTY_TH);
    localparam logic [PTR_WIDTH:0]   CNT_ONE  = (PTR_WIDTH+1)'(1);
    localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(NUM_OF_ENTRIES - 1);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);

    logic [DAT_WIDTH-1:0] mem [NUM_OF_ENTRIES];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [PTR_WIDTH:0]   used_nxt;
    logic                 wr_acc;
    logic                 rd_acc;
    logic                 fetch;

    // Depth need not be a power of two, so wrap explicitly at the last entry.
    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    assign wr_acc = wr_op & ~full;

`ifdef GENERIC_1CLK_FIFO_FWFT_EN
    // The array read register doubles as the head register; refill whenever the
    // array still holds words behind the head and the head is free or being popped.
    assign rd_acc = rd_op & rd_valid;
    assign fetch  = (entry_used != {{PTR_WIDTH{1'b0}}, rd_valid}) & (~rd_valid | rd_op);
    assign empty  = ~rd_valid;
`else
    assign rd_acc = rd_op & ~empty;
    assign fetch  = rd_acc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            empty <= 1'b1;
        end else begin
            empty <= (used_nxt == '0);
        end
    end
`endif

    always_comb begin
        used_nxt = entry_used;
        if (wr_acc && !rd_acc) begin
            used_nxt = entry_used + CNT_ONE;
        end else if (!wr_acc && rd_acc) begin
            used_nxt = entry_used - CNT_ONE;
        end
    end

    // Storage is not reset; unmasked bits keep their previous array content.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= (mem[wr_ptr] & ~wr_mask) | (wr_data & wr_mask);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            entry_used   <= '0;
            full         <= 1'b0;
            afull        <= 1'b0;
            aempty       <= 1'b1;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            wr_full_err  <= 1'b0;
            rd_empty_err <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (fetch) begin
                rd_ptr  <= ptr_inc(rd_ptr);
                rd_data <= mem[rd_ptr];
            end
            entry_used   <= used_nxt;
            full         <= (used_nxt == CAP);
            afull        <= (used_nxt >= AF_LVL);
            aempty       <= (used_nxt <= AE_LVL);
            // A new error in the same cycle as err_clr wins.
            wr_full_err  <= (wr_full_err & ~err_clr) | (wr_op & full);
            rd_empty_err <= (rd_empty_err & ~err_clr) | (rd_op & empty);
`ifdef GENERIC_1CLK_FIFO_FWFT_EN
            if (fetch) begin
                rd_valid <= 1'b1;
            end else if (rd_acc) begin
                rd_valid <= 1'b0;
            end
`else
            rd_valid <= rd_acc;
`endif
        end
    end

endmodule

// File: tb/tb_generic_1clk_fifo_env_ram.sv
// tb/tb_generic_1clk_fifo_env_ram.sv - self-checking bench for generic_1clk_fifo_env_ram
module tb_generic_1clk_fifo_env_ram;
    localparam int W = 36;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic         b_wr_op, b_rd_op, b_err_clr;
    logic [W-1:0] b_wr_data, b_wr_mask, b_rd_data;
    logic         b_full, b_afull, b_wfe, b_rv, b_empty, b_aempty, b_ree;
    logic [8:0]   b_used;
    logic         s_wr_op, s_rd_op, s_err_clr;
    logic [W-1:0] s_wr_data, s_wr_mask, s_rd_data;
    logic         s_full, s_afull, s_wfe, s_rv, s_empty, s_aempty, s_ree;
    logic [3:0]   s_used;

    generic_1clk_fifo_env_ram u_big (
        .clk(clk), .reset_n(reset_n), .wr_op(b_wr_op), .wr_data(b_wr_data),
        .wr_mask(b_wr_mask), .full(b_full), .afull(b_afull), .wr_full_err(b_wfe),
        .rd_op(b_rd_op), .rd_data(b_rd_data), .rd_valid(b_rv), .empty(b_empty),
        .aempty(b_aempty), .rd_empty_err(b_ree), .entry_used(b_used), .err_clr(b_err_clr)
    );

    generic_1clk_fifo_env_ram #(
        .DAT_WIDTH(W), .NUM_OF_ENTRIES(5), .PTR_WIDTH(3), .AFULL_TH(4), .AEMPTY_TH(1)
    ) u_small (
        .clk(clk), .reset_n(reset_n), .wr_op(s_wr_op), .wr_data(s_wr_data),
        .wr_mask(s_wr_mask), .full(s_full), .afull(s_afull), .wr_full_err(s_wfe),
        .rd_op(s_rd_op), .rd_data(s_rd_data), .rd_valid(s_rv), .empty(s_empty),
        .aempty(s_aempty), .rd_empty_err(s_ree), .entry_used(s_used), .err_clr(s_err_clr)
    );

    int total = 0;
    int bad = 0;

    // Reference model: words in flight = writes accepted - reads accepted;
    // slot of the k-th word ever written since reset is k mod capacity.
    int           CAP [2] = '{256, 5};
    int           AF  [2] = '{240, 4};
    int           AE  [2] = '{16, 1};
    int           m_wcnt [2];
    int           m_rcnt [2];
    logic         m_werr [2];
    logic         m_rerr [2];
    logic         m_rv   [2];
    logic [W-1:0] m_rdata[2];
    logic [W-1:0] m_mem  [2][256];

    task automatic chk(input int d, input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL dut%0d %s observed=%0h expected=%0h", d, tag, obs, exp);
        end
    endtask

    task automatic idle();
        b_wr_op = 0; b_rd_op = 0; b_err_clr = 0; b_wr_data = '0; b_wr_mask = '0;
        s_wr_op = 0; s_rd_op = 0; s_err_clr = 0; s_wr_data = '0; s_wr_mask = '0;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_wcnt[d] = 0; m_rcnt[d] = 0; m_werr[d] = 0; m_rerr[d] = 0;
            m_rv[d] = 0; m_rdata[d] = '0;
        end
    endtask

    task automatic check(input int d);
        logic [8:0]   ou;
        logic [W-1:0] od;
        logic         of, oaf, oe, oae, orv, owe, ore;
        int           u;
        u = m_wcnt[d] - m_rcnt[d];
        if (d == 0) begin
            ou = b_used; od = b_rd_data; of = b_full; oaf = b_afull; oe = b_empty;
            oae = b_aempty; orv = b_rv; owe = b_wfe; ore = b_ree;
        end else begin
            ou = {5'b0, s_used}; od = s_rd_data; of = s_full; oaf = s_afull; oe = s_empty;
            oae = s_aempty; orv = s_rv; owe = s_wfe; ore = s_ree;
        end
        chk(d, "entry_used", 64'(ou), 64'(u));
        chk(d, "full", of, u == CAP[d]);
        chk(d, "afull", oaf, u >= AF[d]);
        chk(d, "empty", oe, u == 0);
        chk(d, "aempty", oae, u <= AE[d]);
        chk(d, "rd_valid", orv, m_rv[d]);
        chk(d, "rd_data", od, m_rdata[d]);
        chk(d, "wr_full_err", owe, m_werr[d]);
        chk(d, "rd_empty_err", ore, m_rerr[d]);
    endtask

    task automatic cyc(input int d, input logic w, input logic [W-1:0] data,
                       input logic [W-1:0] mask, input logic r, input logic clr);
        int   u, a;
        logic fl, em, wa, ra;
        if (d == 0) begin
            b_wr_op = w; b_wr_data = data; b_wr_mask = mask; b_rd_op = r; b_err_clr = clr;
        end else begin
            s_wr_op = w; s_wr_data = data; s_wr_mask = mask; s_rd_op = r; s_err_clr = clr;
        end
        u  = m_wcnt[d] - m_rcnt[d];
        fl = (u == CAP[d]);
        em = (u == 0);
        wa = w && !fl;
        ra = r && !em;
        @(posedge clk); #1;
        idle();
        if (ra) begin
            m_rdata[d] = m_mem[d][m_rcnt[d] % CAP[d]];
            m_rcnt[d]++;
        end
        if (wa) begin
            a = m_wcnt[d] % CAP[d];
            m_mem[d][a] = (m_mem[d][a] & ~mask) | (data & mask);
            m_wcnt[d]++;
        end
        m_rv[d]   = ra;
        m_werr[d] = (m_werr[d] && !clr) || (w && fl);
        m_rerr[d] = (m_rerr[d] && !clr) || (r && em);
        check(d);
    endtask

    function automatic logic [W-1:0] rnd();
        return W'({$urandom, $urandom});
    endfunction

    initial begin
        int first_af;
        logic [W-1:0] exp_q [10];
        idle();
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check(0);
        check(1);
        reset_n = 1'b1;

`ifdef GENERIC_1CLK_FIFO_FWFT_EN
        b_wr_op = 1; b_wr_data = 36'hA; b_wr_mask = '1;
        @(posedge clk); #1; idle();
        chk(0, "fwft_n1_valid", b_rv, 0);
        chk(0, "fwft_n1_used", b_used, 1);
        chk(0, "fwft_n1_empty", b_empty, 1);
        @(posedge clk); #1;
        chk(0, "fwft_n2_valid", b_rv, 1);
        chk(0, "fwft_n2_data", b_rd_data, 36'hA);
        b_rd_op = 1;
        @(posedge clk); #1; idle();
        chk(0, "fwft_pop_used", b_used, 0);
        chk(0, "fwft_pop_valid", b_rv, 0);
        for (int i = 0; i < 10; i++) begin
            exp_q[i] = rnd();
            b_wr_op = 1; b_wr_data = exp_q[i]; b_wr_mask = '1;
            @(posedge clk); #1;
        end
        idle();
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            chk(0, "fwft_stream_valid", b_rv, 1);
            chk(0, "fwft_stream_data", b_rd_data, exp_q[i]);
            chk(0, "fwft_stream_used", 64'(b_used), 64'(10 - i));
            b_rd_op = 1;
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        #1;
        chk(0, "fwft_rst_valid", b_rv, 0);
        chk(0, "fwft_rst_used", b_used, 0);
        idle();
        @(negedge clk); reset_n = 1'b1;
`else
        first_af = -1;
        for (int i = 0; i < 256; i++) begin
            cyc(0, 1'b1, W'(i), '1, 1'b0, 1'b0);
            if (b_afull && first_af < 0) first_af = i + 1;
        end
        chk(0, "afull_first_used", 64'(first_af), 240);
        chk(0, "full_at_256", b_full, 1);
        cyc(0, 1'b1, W'(256), '1, 1'b0, 1'b0);
        chk(0, "overflow_err", b_wfe, 1);
        chk(0, "overflow_used", b_used, 256);
        for (int i = 0; i < 256; i++) begin
            cyc(0, 1'b0, '0, '0, 1'b1, 1'b0);
            chk(0, "drain_order", b_rd_data, W'(i));
        end
        chk(0, "drain_empty", b_empty, 1);
        cyc(0, 1'b0, '0, '0, 1'b1, 1'b0);
        chk(0, "underflow_err", b_ree, 1);
        cyc(0, 1'b0, '0, '0, 1'b0, 1'b1);
        chk(0, "clr_rd_err", b_ree, 0);
        chk(0, "clr_wr_err", b_wfe, 0);

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 5; k++) cyc(1, 1'b1, W'(r * 5 + k + 1), '1, 1'b0, 1'b0);
            for (int k = 0; k < 5; k++) begin
                cyc(1, 1'b0, '0, '0, 1'b1, 1'b0);
                chk(1, "wrap_order", s_rd_data, W'(r * 5 + k + 1));
            end
        end
        for (int k = 0; k < 3; k++) cyc(1, 1'b1, rnd(), '1, 1'b0, 1'b0);
        cyc(1, 1'b1, rnd(), '1, 1'b1, 1'b0);
        chk(1, "simul_at_3", s_used, 3);
        for (int k = 0; k < 3; k++) cyc(1, 1'b0, '0, '0, 1'b1, 1'b0);

        cyc(1, 1'b1, 36'hF_FFFF_FFFF, '1, 1'b0, 1'b0);
        cyc(1, 1'b0, '0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) cyc(1, 1'b1, rnd(), '1, 1'b0, 1'b0);
        cyc(1, 1'b1, '0, 36'h0_0000_FFFF, 1'b0, 1'b0);
        chk(1, "mask_full", s_full, 1);
        cyc(1, 1'b1, rnd(), '1, 1'b1, 1'b0);
        chk(1, "full_simul_used", s_used, 4);
        chk(1, "full_simul_err", s_wfe, 1);
        for (int k = 0; k < 4; k++) cyc(1, 1'b0, '0, '0, 1'b1, 1'b0);
        chk(1, "mask_result", s_rd_data, 36'hF_FFFF_0000);
        cyc(1, 1'b1, rnd(), '1, 1'b1, 1'b0);
        chk(1, "empty_simul_used", s_used, 1);
        chk(1, "empty_simul_err", s_ree, 1);
        cyc(1, 1'b0, '0, '0, 1'b1, 1'b0);
        cyc(1, 1'b0, '0, '0, 1'b1, 1'b1);
        chk(1, "set_wins_over_clr", s_ree, 1);
        cyc(1, 1'b0, '0, '0, 1'b0, 1'b1);
        chk(1, "clr_after_set", s_ree, 0);

        for (int i = 0; i < 400; i++)
            cyc(1, 1'($urandom), rnd(), rnd(), 1'($urandom), $urandom_range(0, 7) == 0);
        for (int i = 0; i < 600; i++)
            cyc(0, (i < 300) ? ($urandom_range(0, 3) != 0) : 1'($urandom), rnd(), rnd(),
                (i < 300) ? ($urandom_range(0, 3) == 0) : 1'($urandom), $urandom_range(0, 15) == 0);

        cyc(0, 1'b1, rnd(), '1, 1'b0, 1'b0);
        cyc(0, 1'b0, '0, '0, 1'b1, 1'b0);
        reset_n = 1'b0;
        #1;
        chk(0, "midrst_valid", b_rv, 0);
        chk(0, "midrst_used", b_used, 0);
        chk(1, "midrst_used", s_used, 0);
        model_reset();
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        check(0);
        check(1);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
